// File: rtl/ballot_controller.sv
// Ballot controller: synchronized, debounced arm and vote buttons drive a
// four-state ballot FSM with timeout, multi-press reject and a saturating tally.
module ballot_controller #(
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       p1,
  input  logic       p2,
  input  logic       p3,
  input  logic       p4,
  output logic       ready,
  output logic       vote_valid,
  output logic [1:0] vote_sel,
  output logic       reject,
  output logic       timeout,
  output logic [7:0] ballots
);

  localparam int unsigned N_IN  = 5;
  localparam int unsigned DEB_W = 8;
  localparam int unsigned TMR_W = 16;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, ARMED, CAST, RELEASE} state_t;

  logic [N_IN-1:0]  raw;
  logic [N_IN-1:0]  sync1;
  logic [N_IN-1:0]  sync2;
  logic [N_IN-1:0]  deb;
  logic [DEB_W-1:0] deb_cnt [N_IN];
  logic             en_prev;

  logic [3:0]       p_deb;
  logic             en_rise;
  logic             p_any;
  logic             p_multi;
  logic [1:0]       p_idx;

  state_t           state_q;
  state_t           state_d;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic             vote_c;
  logic             reject_c;
  logic             timeout_c;

  // Bit 0 is the arm button, bits 4:1 are the vote buttons p1..p4.
  assign raw = {p4, p3, p2, p1, enable};

  // Two-flop synchronizers followed by a per-input stability counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      en_prev <= 1'b0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      en_prev <= deb[0];
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign p_deb   = deb[4:1];
  assign en_rise = deb[0] & ~en_prev;
  assign p_any   = |p_deb;
  assign p_multi = |(p_deb & (p_deb - 4'd1));

  // Index of the pressed button; only meaningful when exactly one is high.
  always_comb begin
    p_idx = 2'd0;
    case (p_deb)
      4'b0010: p_idx = 2'd1;
      4'b0100: p_idx = 2'd2;
      4'b1000: p_idx = 2'd3;
      default: p_idx = 2'd0;
    endcase
  end

  // Next-state logic; a press in the expiry cycle wins over the timeout.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    vote_c    = 1'b0;
    reject_c  = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_rise && !p_any) begin
          state_d = ARMED;
          timer_d = '0;
        end
      end
      ARMED: begin
        timer_d = timer_q + TMR_W'(1);
        if (p_multi) begin
          reject_c = 1'b1;
          state_d  = RELEASE;
        end else if (p_any) begin
          vote_c  = 1'b1;
          state_d = CAST;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_c = 1'b1;
          state_d   = IDLE;
        end
      end
      CAST: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!p_any) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, timer and registered outputs; pulses coincide with the state they announce.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      ready      <= 1'b0;
      vote_valid <= 1'b0;
      vote_sel   <= 2'd0;
      reject     <= 1'b0;
      timeout    <= 1'b0;
      ballots    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ready      <= (state_d == ARMED);
      vote_valid <= vote_c;
      reject     <= reject_c;
      timeout    <= timeout_c;
      if (vote_c) begin
        vote_sel <= p_idx;
        if (ballots != CNT_W'(255)) begin
          ballots <= ballots + CNT_W'(1);
        end
      end
    end
  end

endmodule
